// File: rtl/fib_gen_pkg.sv
// Shared types for the Fibonacci sequence generator.
package fib_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/fib_add.sv
// WIDTH-bit adder with carry-out; the carry feeds the sticky overflow flag.
module fib_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: F(n) from two seeds, optional streaming of terms.
//
//   state | meaning
//   IDLE  | waiting for start_i; result of last run held on f_o/ovf_o
//   OP    | n_reg counts down to 1 while t0/t1 step through the sequence
//   DONE  | final term on f_o; done_tick_o high for this one cycle
module fib_seq_gen
  import fib_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NW    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NW-1:0]    n_i,
  input  logic [WIDTH-1:0] seed0_i,
  input  logic [WIDTH-1:0] seed1_i,
  input  logic             mode_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic             done_tick_o,
  output logic [WIDTH-1:0] f_o,
  output logic             ovf_o
);

  state_e           state;
  logic [WIDTH-1:0] t0;
  logic [WIDTH-1:0] t1;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [NW-1:0]    n_reg;
  logic             mode_reg;
  logic             ovf;

  fib_add #(.WIDTH(WIDTH)) u_add (
    .a_i    (t1),
    .b_i    (t0),
    .sum_o  (sum),
    .carry_o(carry)
  );

  // Abort is checked first in OP so it beats a coincident move to DONE;
  // the registers freeze on abort so the partial term stays visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      t0       <= '0;
      t1       <= '0;
      n_reg    <= '0;
      mode_reg <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            n_reg    <= n_i;
            mode_reg <= mode_i;
            t0       <= seed0_i;
            t1       <= seed1_i;
            ovf      <= 1'b0;
            state    <= OP;
          end
        end
        OP: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (n_reg == '0) begin
            t1    <= t0;
            state <= DONE;
          end else if (n_reg == NW'(1)) begin
            state <= DONE;
          end else begin
            t1    <= sum;
            t0    <= t1;
            n_reg <= n_reg - NW'(1);
            if (carry) ovf <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o     = (state == IDLE);
  assign done_tick_o = (state == DONE);
  assign valid_o     = (state == OP) && (mode_reg == MODE_STREAM) && (n_reg > NW'(1));
  assign f_o         = t1;
  assign ovf_o       = ovf;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed self-checking bench for fib_seq_gen (32-bit and 8-bit instances).
module tb_fib_seq_gen;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  logic        start_a = 1'b0, mode_a = 1'b0, abort_a = 1'b0;
  logic [5:0]  n_a = '0;
  logic [31:0] s0_a = '0, s1_a = '0;
  logic        ready_a, valid_a, done_a, ovf_a;
  logic [31:0] f_a;

  logic        start_b = 1'b0, mode_b = 1'b0, abort_b = 1'b0;
  logic [5:0]  n_b = '0;
  logic [7:0]  s0_b = '0, s1_b = '0;
  logic        ready_b, valid_b, done_b, ovf_b;
  logic [7:0]  f_b;

  int checks = 0;
  int errors = 0;

  fib_seq_gen #(.WIDTH(32), .NW(6)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_a), .n_i(n_a),
    .seed0_i(s0_a), .seed1_i(s1_a), .mode_i(mode_a), .abort_i(abort_a),
    .ready_o(ready_a), .valid_o(valid_a), .done_tick_o(done_a),
    .f_o(f_a), .ovf_o(ovf_a)
  );

  fib_seq_gen #(.WIDTH(8), .NW(6)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_b), .n_i(n_b),
    .seed0_i(s0_b), .seed1_i(s1_b), .mode_i(mode_b), .abort_i(abort_b),
    .ready_o(ready_b), .valid_o(valid_b), .done_tick_o(done_b),
    .f_o(f_b), .ovf_o(ovf_b)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Start pulse; returns at the sample point of cycle 1 (start cycle = 0).
  task automatic kick_a(input logic [5:0] n, input logic [31:0] s0, input logic [31:0] s1,
                        input logic m);
    @(posedge clk_i); #1;
    n_a = n; s0_a = s0; s1_a = s1; mode_a = m; start_a = 1'b1;
    @(posedge clk_i); #1;
    start_a = 1'b0;
  endtask

  task automatic kick_b(input logic [5:0] n, input logic [7:0] s0, input logic [7:0] s1);
    @(posedge clk_i); #1;
    n_b = n; s0_b = s0; s1_b = s1; mode_b = 1'b0; start_b = 1'b1;
    @(posedge clk_i); #1;
    start_b = 1'b0;
  endtask

  // Bounded wait for done; dc stays -1 if the budget runs out.
  task automatic run_a(output int dc, output logic [31:0] fd, output logic od, output int vc);
    dc = -1; fd = '0; od = 1'b0; vc = 0;
    for (int c = 1; c <= 80; c++) begin
      if (valid_a) vc++;
      if (done_a) begin
        dc = c; fd = f_a; od = ovf_a;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic run_b(output int dc, output logic [7:0] fd, output logic od);
    dc = -1; fd = '0; od = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (done_b) begin
        dc = c; fd = f_b; od = ovf_b;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset;
    @(posedge clk_i); #1;
    checks++;
    if ({ready_a, valid_a, done_a, ovf_a} !== 4'b1000 || f_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_a: rdy/val/done/ovf=%b f=%0d, want 1000 f=0",
               {ready_a, valid_a, done_a, ovf_a}, f_a);
    end
    checks++;
    if ({ready_b, valid_b, done_b, ovf_b} !== 4'b1000 || f_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: rdy/val/done/ovf=%b f=%0d, want 1000 f=0",
               {ready_b, valid_b, done_b, ovf_b}, f_b);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_single;
    int dc, vc; logic [31:0] fd; logic od;
    kick_a(6'd10, 32'd0, 32'd1, 1'b0);
    run_a(dc, fd, od, vc);
    checks++;
    if (dc !== 11) begin errors++; $display("FAIL single_cycle: got %0d want 11", dc); end
    checks++;
    if (fd !== 32'd55) begin errors++; $display("FAIL single_f: got %0d want 55", fd); end
    checks++;
    if (od !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", od); end
    checks++;
    if (vc !== 0) begin errors++; $display("FAIL single_valid: %0d valid cycles, want 0", vc); end
    @(posedge clk_i); #1;
    checks++;
    if (done_a !== 1'b0 || ready_a !== 1'b1 || f_a !== 32'd55) begin
      errors++;
      $display("FAIL single_hold: done=%b ready=%b f=%0d, want 0 1 55", done_a, ready_a, f_a);
    end
  endtask

  task automatic test_small_n;
    int dc, vc; logic [31:0] fd; logic od;
    kick_a(6'd0, 32'd3, 32'd4, 1'b0);
    run_a(dc, fd, od, vc);
    checks++;
    if (dc !== 2 || fd !== 32'd3) begin
      errors++; $display("FAIL n0: cycle=%0d f=%0d, want 2 3", dc, fd);
    end
    kick_a(6'd1, 32'd3, 32'd4, 1'b0);
    run_a(dc, fd, od, vc);
    checks++;
    if (dc !== 2 || fd !== 32'd4) begin
      errors++; $display("FAIL n1: cycle=%0d f=%0d, want 2 4", dc, fd);
    end
  endtask

  task automatic test_width8_ovf;
    int dc; logic [7:0] fd; logic od;
    kick_b(6'd13, 8'd0, 8'd1);
    run_b(dc, fd, od);
    checks++;
    if (dc !== 14 || fd !== 8'd233 || od !== 1'b0) begin
      errors++; $display("FAIL w8_n13: cycle=%0d f=%0d ovf=%b, want 14 233 0", dc, fd, od);
    end
    kick_b(6'd14, 8'd0, 8'd1);
    run_b(dc, fd, od);
    checks++;
    if (dc !== 15 || fd !== 8'd121 || od !== 1'b1) begin
      errors++; $display("FAIL w8_n14: cycle=%0d f=%0d ovf=%b, want 15 121 1", dc, fd, od);
    end
    @(posedge clk_i); #1;
    checks++;
    if (ovf_b !== 1'b1 || f_b !== 8'd121) begin
      errors++; $display("FAIL w8_hold: ovf=%b f=%0d, want 1 121", ovf_b, f_b);
    end
    kick_b(6'd2, 8'd0, 8'd1);
    checks++;
    if (ovf_b !== 1'b0) begin errors++; $display("FAIL w8_clear: ovf=%b want 0", ovf_b); end
    run_b(dc, fd, od);
    checks++;
    if (dc !== 3 || fd !== 8'd1 || od !== 1'b0) begin
      errors++; $display("FAIL w8_n2: cycle=%0d f=%0d ovf=%b, want 3 1 0", dc, fd, od);
    end
  endtask

  task automatic test_stream;
    logic [31:0] exp_f [1:4];
    int dc;
    exp_f[1] = 32'd1; exp_f[2] = 32'd1; exp_f[3] = 32'd2; exp_f[4] = 32'd3;
    dc = -1;
    kick_a(6'd5, 32'd0, 32'd1, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (valid_a !== (c <= 4)) begin
        errors++; $display("FAIL stream_valid c%0d: got %b want %b", c, valid_a, (c <= 4));
      end
      if (c <= 4) begin
        checks++;
        if (f_a !== exp_f[c]) begin
          errors++; $display("FAIL stream_f c%0d: got %0d want %0d", c, f_a, exp_f[c]);
        end
      end
      if (done_a && dc < 0) dc = c;
      if (c == 6) begin
        checks++;
        if (done_a !== 1'b1 || f_a !== 32'd5) begin
          errors++; $display("FAIL stream_done: done=%b f=%0d, want 1 5", done_a, f_a);
        end
      end
      if (c < 7) begin @(posedge clk_i); #1; end
    end
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL stream_done_cycle: got %0d want 6", dc); end
  endtask

  task automatic test_abort;
    int dc, vc, ndone; logic [31:0] fd; logic od;
    kick_a(6'd20, 32'd0, 32'd1, 1'b0);
    @(posedge clk_i); #1;
    n_a = 6'd1; s0_a = 32'd9; s1_a = 32'd9; start_a = 1'b1;
    @(posedge clk_i); #1;
    start_a = 1'b0; abort_a = 1'b1;
    checks++;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL abort_busy: ready=%b want 0", ready_a); end
    @(posedge clk_i); #1;
    abort_a = 1'b0;
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || f_a !== 32'd2) begin
      errors++; $display("FAIL abort_idle: ready=%b done=%b f=%0d, want 1 0 2", ready_a, done_a, f_a);
    end
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      if (done_a) ndone++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_nodone: %0d done pulses want 0", ndone); end
    // abort coinciding with the final OP cycle (n=1)
    kick_a(6'd1, 32'd3, 32'd4, 1'b0);
    abort_a = 1'b1;
    @(posedge clk_i); #1;
    abort_a = 1'b0;
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0) begin
      errors++; $display("FAIL abort_wins: ready=%b done=%b, want 1 0", ready_a, done_a);
    end
    @(posedge clk_i); #1;
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL abort_wins_late: done=%b want 0", done_a); end
    kick_a(6'd5, 32'd2, 32'd1, 1'b0);
    run_a(dc, fd, od, vc);
    checks++;
    if (dc !== 6 || fd !== 32'd11) begin
      errors++; $display("FAIL after_abort: cycle=%0d f=%0d, want 6 11", dc, fd);
    end
  endtask

  task automatic test_reset_mid;
    int dc, vc; logic [31:0] fd; logic od;
    kick_a(6'd10, 32'd0, 32'd1, 1'b1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checks++;
    if (valid_a !== 1'b1 || f_a !== 32'd2) begin
      errors++; $display("FAIL pre_reset: valid=%b f=%0d, want 1 2", valid_a, f_a);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({ready_a, valid_a, done_a, ovf_a} !== 4'b1000 || f_a !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: rdy/val/done/ovf=%b f=%0d, want 1000 f=0",
               {ready_a, valid_a, done_a, ovf_a}, f_a);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    kick_a(6'd3, 32'd0, 32'd1, 1'b0);
    run_a(dc, fd, od, vc);
    checks++;
    if (dc !== 4 || fd !== 32'd2 || od !== 1'b0) begin
      errors++; $display("FAIL post_reset: cycle=%0d f=%0d ovf=%b, want 4 2 0", dc, fd, od);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_small_n();
    test_width8_ovf();
    test_stream();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
